// File: rtl/path_stack_ctrl.sv
// Move stack for path search: push/pop/overwrite of 2-bit moves, plus a
// bottom-to-top replay stream with valid/ready handshake.
// Optional: define PATH_STACK_ERR_CLR_EN so that clear also clears err.
module path_stack_ctrl #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic [1:0]  dir_in,
  input  logic        clear,
  input  logic        run,
  input  logic        out_rdy,
  output logic [1:0]  top_dir,
  output logic [AW:0] depth,
  output logic        empty,
  output logic        full,
  output logic        out_valid,
  output logic [1:0]  out_dir,
  output logic        replay_done,
  output logic        err
);

  typedef enum logic {STACK, REPLAY} state_t;

  state_t          state, state_nxt;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   wr_idx;
  logic            wr_en;
  logic            run_go;
  logic            last;
  logic            accept;

  assign top_idx = AW'(depth - 1'b1);
  assign empty   = (depth == '0);
  assign full    = (depth == (AW+1)'(DEPTH));
  assign top_dir = empty ? 2'd0 : mem[top_idx];

  // run only starts a replay on a cycle with no other stack command
  assign run_go = run && !clear && !push && !pop;
  assign accept = out_valid && out_rdy;
  assign last   = ({1'b0, rd_ptr} == depth - 1'b1);

  // push+pop on a non-empty stack rewrites the top; otherwise write at depth
  assign wr_en  = (state == STACK) && !clear && push && (pop || !full);
  assign wr_idx = (pop && !empty) ? top_idx : depth[AW-1:0];

  always_ff @(posedge clk) begin
    if (rst) state <= STACK;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STACK:  if (run_go && !empty) state_nxt = REPLAY;
      REPLAY: if (accept && last)   state_nxt = STACK;
      default: state_nxt = STACK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_idx] <= dir_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth       <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      out_dir     <= 2'd0;
      replay_done <= 1'b0;
      err         <= 1'b0;
    end else begin
      replay_done <= 1'b0;
      if (state == STACK) begin
        if (clear) begin
          depth <= '0;
`ifdef PATH_STACK_ERR_CLR_EN
          err   <= 1'b0;
`endif
        end else if (push && pop) begin
          if (empty) depth <= (AW+1)'(1);
        end else if (push) begin
          if (!full) depth <= depth + 1'b1;
          else       err   <= 1'b1;
        end else if (pop) begin
          if (!empty) depth <= depth - 1'b1;
          else        err   <= 1'b1;
        end else if (run_go) begin
          if (empty) begin
            replay_done <= 1'b1;
          end else begin
            rd_ptr    <= '0;
            out_valid <= 1'b1;
            out_dir   <= mem[0];
          end
        end
      end else if (accept) begin
        if (last) begin
          out_valid   <= 1'b0;
          replay_done <= 1'b1;
        end else begin
          rd_ptr  <= rd_ptr + 1'b1;
          out_dir <= mem[rd_ptr + 1'b1];
        end
      end
    end
  end

endmodule

// File: tb/tb_path_stack_ctrl.sv
// Directed bench for path_stack_ctrl: a vector table for stack operations and
// hand-written sequences for fill, replay handshake, empty run and reset abort.
module tb_path_stack_ctrl;
  localparam int DEPTH = 256;
  localparam int AW    = 8;
`ifdef PATH_STACK_ERR_CLR_EN
  localparam int ERR_AFTER_CLR = 0;
`else
  localparam int ERR_AFTER_CLR = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, push, pop, clear, run, out_rdy;
  logic [1:0]  dir_in, top_dir, out_dir;
  logic [AW:0] depth;
  logic        empty, full, out_valid, replay_done, err;

  int n_chk = 0;
  int n_fail = 0;

  path_stack_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .dir_in(dir_in),
    .clear(clear), .run(run), .out_rdy(out_rdy), .top_dir(top_dir),
    .depth(depth), .empty(empty), .full(full), .out_valid(out_valid),
    .out_dir(out_dir), .replay_done(replay_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       push, pop, clear;
    logic [1:0] dir;
    int         e_depth, e_top, e_empty, e_err;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle();
    push = 0; pop = 0; clear = 0; run = 0; out_rdy = 0; dir_in = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  task automatic push1(input logic [1:0] d);
    push = 1; dir_in = d; tick(); idle();
  endtask

  int got [$];
  int held, done_cnt, valid_seen;
  logic [0:3] rdy_pat;

  initial begin
    vt[0] = '{1,0,0,2'd1, 1,1,0,0};
    vt[1] = '{1,0,0,2'd2, 2,2,0,0};
    vt[2] = '{1,0,0,2'd3, 3,3,0,0};
    vt[3] = '{0,1,0,2'd0, 2,2,0,0};
    vt[4] = '{1,1,0,2'd0, 2,0,0,0};
    vt[5] = '{0,1,0,2'd0, 1,1,0,0};
    vt[6] = '{0,1,0,2'd0, 0,0,1,0};
    vt[7] = '{0,1,0,2'd0, 0,0,1,1};
    vt[8] = '{1,1,0,2'd2, 1,2,0,1};
    vt[9] = '{0,0,1,2'd0, 0,0,1,ERR_AFTER_CLR};

    idle(); rst = 1; tick();
    do_reset();
    chk("rst_depth", int'(depth), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_top", int'(top_dir), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_done", int'(replay_done), 0);

    foreach (vt[i]) begin
      push = vt[i].push; pop = vt[i].pop; clear = vt[i].clear; dir_in = vt[i].dir;
      tick(); idle();
      chk($sformatf("v%0d_depth", i), int'(depth), vt[i].e_depth);
      chk($sformatf("v%0d_top", i), int'(top_dir), vt[i].e_top);
      chk($sformatf("v%0d_empty", i), int'(empty), vt[i].e_empty);
      chk($sformatf("v%0d_err", i), int'(err), vt[i].e_err);
    end

    // fill to capacity, then overflow
    do_reset();
    for (int i = 0; i < DEPTH; i++) push1(2'(i % 4));
    chk("fill_full", int'(full), 1);
    chk("fill_depth", int'(depth), DEPTH);
    chk("fill_top", int'(top_dir), 3);
    chk("fill_err", int'(err), 0);
    push1(2'd1);
    chk("ovf_depth", int'(depth), DEPTH);
    chk("ovf_err", int'(err), 1);
    chk("ovf_top", int'(top_dir), 3);

    // replay 1,0,3 with out_rdy 1,0,1,1; a push during replay is ignored
    do_reset();
    push1(2'd1); push1(2'd0); push1(2'd3);
    run = 1; tick(); idle();
    rdy_pat = 4'b1011; done_cnt = 0; held = -1;
    for (int k = 0; k < 8; k++) begin
      out_rdy = (k < 4) ? rdy_pat[k] : 1'b1;
      if (k == 1) push = 1;
      if (replay_done) done_cnt++;
      if (k == 1) held = int'(out_dir);
      if (k == 2) chk("stall_hold", int'(out_dir), held);
      if (out_valid && out_rdy) got.push_back(int'(out_dir));
      tick(); idle();
    end
    chk("rp_count", got.size(), 3);
    if (got.size() == 3) begin
      chk("rp_0", got[0], 1);
      chk("rp_1", got[1], 0);
      chk("rp_2", got[2], 3);
    end
    chk("rp_done_cnt", done_cnt, 1);
    chk("rp_depth", int'(depth), 3);
    chk("rp_top", int'(top_dir), 3);
    chk("rp_err", int'(err), 0);
    chk("rp_valid_off", int'(out_valid), 0);

    // run on empty stack
    do_reset();
    run = 1; tick(); idle();
    chk("er_done", int'(replay_done), 1);
    valid_seen = int'(out_valid);
    tick();
    chk("er_done_off", int'(replay_done), 0);
    valid_seen |= int'(out_valid);
    chk("er_novalid", valid_seen, 0);

    // reset in the middle of a replay
    push1(2'd1); push1(2'd2);
    run = 1; tick(); idle();
    chk("ab_valid_on", int'(out_valid), 1);
    chk("ab_dir", int'(out_dir), 1);
    rst = 1; tick(); rst = 0;
    chk("ab_valid", int'(out_valid), 0);
    chk("ab_depth", int'(depth), 0);
    chk("ab_done", int'(replay_done), 0);
    tick();
    chk("ab_done2", int'(replay_done), 0);
    chk("ab_empty", int'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
